tff_updown_counter: RTL and testbench

Synchronous modulo-N up/down counter built structurally from the team's `tff` toggle flip-flop cells, one cell per bit. It is the counting-side consumer of the `tff` cell: each cell's `T` input is driven from next-state logic so that `Q` follows a programmed count sequence. It is the building block for the structural counter chain, cascading through `TC`.

---
 rtl/tff_updown_counter_pkg.sv | 14 +
 rtl/tff_updown_counter_tff.sv | 26 ++
 rtl/tff_updown_counter.sv | 77 +++++++
 tb/tb_tff_updown_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_updown_counter_pkg.sv
// Shared constants for the structural tff-based up/down counters.
package tff_updown_counter_pkg;

  localparam logic        DIR_UP     = 1'b1;
  localparam logic        DIR_DOWN   = 1'b0;
  localparam int unsigned MOD_DECADE = 10;
  localparam int unsigned WIDTH_DFLT = 4;

  // True when the count range spans the full binary range of the register.
  function automatic bit is_pow2_modulus(input int unsigned width, input int unsigned modulus);
    return modulus == (32'd1 << width);
  endfunction

endpackage

// File: rtl/tff_updown_counter_tff.sv
// Toggle flip-flop cell: Q inverts on a rising C edge when T is high.
module tff (
  output logic Q,
  output logic Qn,
  input  logic C,
  input  logic T,
  input  logic R
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    if (T) q_d = ~q_q;
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) q_q <= 1'b0;
    else    q_q <= q_d;
  end

  assign Q  = q_q;
  assign Qn = ~q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-MODULUS up/down counter with parallel load, built from one tff cell per bit.
module tff_updown_counter
  import tff_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DFLT,
  parameter int unsigned MODULUS = MOD_DECADE
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  if (WIDTH == 0 || WIDTH > 16) begin : g_bad_width
    $error("tff_updown_counter: WIDTH %0d outside 1..16", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
    $error("tff_updown_counter: MODULUS %0d outside 2..2^WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam bit               POW2  = is_pow2_modulus(WIDTH, MODULUS);

  logic [WIDTH-1:0] next_c;
  logic [WIDTH-1:0] t_c;
  logic [WIDTH-1:0] qn_unused;
  logic             at_max_c;
  logic             at_zero_c;
  logic             tc_c;
  logic             wrap_d;
  logic             wrap_q;

  // Terminal count depends only on Q, EN and UP so it can enable the next stage.
  always_comb begin
    at_max_c  = (Q == MAX_V);
    at_zero_c = (Q == '0);
    tc_c      = EN & (((UP == DIR_UP) & at_max_c) | ((UP == DIR_DOWN) & at_zero_c));
  end

  // Next count by priority load > count > hold; full-range moduli wrap by overflow.
  always_comb begin
    next_c = Q;
    if (LD) begin
      next_c = ({1'b0, D} < MOD_X) ? D : MAX_V;
    end else if (EN) begin
      if (UP == DIR_UP) next_c = (!POW2 && at_max_c)  ? '0    : Q + WIDTH'(1);
      else              next_c = (!POW2 && at_zero_c) ? MAX_V : Q - WIDTH'(1);
    end
    t_c    = Q ^ next_c;
    wrap_d = tc_c & ~LD;
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    tff u_tff (
      .Q  (Q[i]),
      .Qn (qn_unused[i]),
      .C  (C),
      .T  (t_c[i]),
      .R  (R)
    );
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) wrap_q <= 1'b0;
    else    wrap_q <= wrap_d;
  end

  assign TC   = tc_c;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Bench for tff_updown_counter: decade counter plus a two-stage MODULUS=16 cascade.
module tb_tff_updown_counter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic       up    = 1'b1;
  logic       ld    = 1'b0;
  logic [3:0] d     = 4'd0;
  logic [3:0] q;
  logic       tc;
  logic       wrap;

  logic       lo_en = 1'b0;
  logic       lo_ld = 1'b0;
  logic       hi_ld = 1'b0;
  logic       cup   = 1'b1;
  logic [3:0] lo_d  = 4'd0;
  logic [3:0] hi_d  = 4'd0;
  logic [3:0] lo_q;
  logic [3:0] hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  int n_vec = 0;
  int n_err = 0;

  int m_q  = 0;
  int m_lo = 0;
  int m_hi = 0;
  bit m_w  = 1'b0;
  bit m_lw = 1'b0;
  bit m_hw = 1'b0;

  int e1[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int e2[4]  = '{1, 0, 9, 8};

  always #5 clk = ~clk;

  tff_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .C(clk), .R(rst_n), .EN(en), .UP(up), .LD(ld), .D(d),
    .Q(q), .TC(tc), .WRAP(wrap)
  );

  tff_updown_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
    .C(clk), .R(rst_n), .EN(lo_en), .UP(cup), .LD(lo_ld), .D(lo_d),
    .Q(lo_q), .TC(lo_tc), .WRAP(lo_wrap)
  );

  tff_updown_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
    .C(clk), .R(rst_n), .EN(lo_tc), .UP(cup), .LD(hi_ld), .D(hi_d),
    .Q(hi_q), .TC(hi_tc), .WRAP(hi_wrap)
  );

  function automatic int nxt(input int qv, input bit e, input bit u, input bit l,
                             input int dv, input int mod);
    if (l) return (dv < mod) ? dv : mod - 1;
    if (!e) return qv;
    return u ? (qv + 1) % mod : (qv + mod - 1) % mod;
  endfunction

  function automatic bit term(input int qv, input bit e, input bit u, input int mod);
    return e && (u ? (qv == mod - 1) : (qv == 0));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model of all three counters.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q  <= 0;  m_w  <= 1'b0;
      m_lo <= 0;  m_lw <= 1'b0;
      m_hi <= 0;  m_hw <= 1'b0;
    end else begin
      m_q  <= nxt(m_q, en, up, ld, int'(d), 10);
      m_w  <= !ld && term(m_q, en, up, 10);
      m_lo <= nxt(m_lo, lo_en, cup, lo_ld, int'(lo_d), 16);
      m_lw <= !lo_ld && term(m_lo, lo_en, cup, 16);
      m_hi <= nxt(m_hi, term(m_lo, lo_en, cup, 16), cup, hi_ld, int'(hi_d), 16);
      m_hw <= !hi_ld && term(m_hi, term(m_lo, lo_en, cup, 16), cup, 16);
    end
  end

  always @(negedge clk) begin
    chk("q",       int'(q),       m_q);
    chk("tc",      int'(tc),      int'(term(m_q, en, up, 10)));
    chk("wrap",    int'(wrap),    int'(m_w));
    chk("lo_q",    int'(lo_q),    m_lo);
    chk("lo_tc",   int'(lo_tc),   int'(term(m_lo, lo_en, cup, 16)));
    chk("lo_wrap", int'(lo_wrap), int'(m_lw));
    chk("hi_q",    int'(hi_q),    m_hi);
    chk("hi_tc",   int'(hi_tc),   int'(term(m_hi, term(m_lo, lo_en, cup, 16), cup, 16)));
    chk("hi_wrap", int'(hi_wrap), int'(m_hw));
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_wrap", int'(wrap), 0);
    #9 rst_n = 1'b1;
    en = 1'b1;
    up = 1'b1;

    // Up-count through the decade wrap
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("t1_q", int'(q), e1[i]);
      chk("t1_tc", int'(tc), int'(e1[i] == 9));
      chk("t1_wrap", int'(wrap), int'(e1[i] == 0));
    end

    // Down-count wrap from a loaded 2
    ld = 1'b1; d = 4'd2;
    tick;
    chk("t2_load", int'(q), 2);
    ld = 1'b0; up = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t2_q", int'(q), e2[i]);
      chk("t2_tc", int'(tc), int'(e2[i] == 0));
      chk("t2_wrap", int'(wrap), int'(e2[i] == 9));
    end

    // Load priority and saturation
    ld = 1'b1; d = 4'd12; en = 1'b1;
    tick;
    chk("t3_sat_q", int'(q), 9);
    chk("t3_sat_wrap", int'(wrap), 0);
    up = 1'b1;
    #1;
    chk("t3_tc_with_ld", int'(tc), 1);
    d = 4'd9;
    tick;
    chk("t3_ldtc_q", int'(q), 9);
    chk("t3_ldtc_wrap", int'(wrap), 0);
    d = 4'd0;
    tick;
    chk("t3_ld0_q", int'(q), 0);
    d = 4'd10;
    tick;
    chk("t3_ld10_q", int'(q), 9);
    ld = 1'b0;

    // Reset kills a pending wrap pulse
    tick;
    chk("t4_wrap_pre", int'(wrap), 1);
    chk("t4_q_pre", int'(q), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_wrap_killed", int'(wrap), 0);
    rst_n = 1'b1;

    // Async reset mid-count at 7
    ld = 1'b1; d = 4'd7;
    tick;
    chk("t4_load7", int'(q), 7);
    ld = 1'b0; en = 1'b1; up = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_q", int'(q), 0);
    ld = 1'b1; d = 4'd5;
    tick;
    chk("t4_held1", int'(q), 0);
    tick;
    chk("t4_held2", int'(q), 0);
    ld = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("t4_resume1", int'(q), 1);
    tick;
    chk("t4_resume2", int'(q), 2);

    // Hold then direction flip
    ld = 1'b1; d = 4'd4;
    tick;
    ld = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t5_hold_q", int'(q), 4);
      chk("t5_hold_tc", int'(tc), 0);
    end
    en = 1'b1; up = 1'b1;
    tick;
    chk("t5_up1", int'(q), 5);
    tick;
    chk("t5_up2", int'(q), 6);
    up = 1'b0;
    tick;
    chk("t5_down", int'(q), 5);
    en = 1'b0;

    // Full binary range and cascade
    lo_ld = 1'b1; lo_d = 4'd14; hi_ld = 1'b1; hi_d = 4'd0; cup = 1'b1;
    tick;
    chk("t6_lo14", int'(lo_q), 14);
    lo_ld = 1'b0; hi_ld = 1'b0; lo_en = 1'b1;
    tick;
    chk("t6_lo15", int'(lo_q), 15);
    chk("t6_lo15_wrap", int'(lo_wrap), 0);
    chk("t6_lo15_tc", int'(lo_tc), 1);
    tick;
    chk("t6_lo0", int'(lo_q), 0);
    chk("t6_lo0_wrap", int'(lo_wrap), 1);
    chk("t6_hi_step", int'(hi_q), 1);
    tick;
    chk("t6_lo1_wrap", int'(lo_wrap), 0);

    lo_ld = 1'b1; lo_d = 4'd0; hi_ld = 1'b1; hi_d = 4'd0;
    tick;
    chk("t6_casc_init", int'(hi_q) * 16 + int'(lo_q), 0);
    lo_ld = 1'b0; hi_ld = 1'b0; lo_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick;
      chk("t6_casc", int'(hi_q) * 16 + int'(lo_q), (i + 1) % 256);
      chk("t6_casc_hitc", int'(hi_tc), int'(((i + 1) % 256) == 255));
      chk("t6_casc_hiwrap", int'(hi_wrap), int'(((i + 1) % 256) == 0));
    end
    lo_en = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
